// File: rtl/ntt_tw_pkg.sv
// Shared constants and helpers for the NTT twiddle fetch path.
//   P_WIDTH    : width of one twiddle word
//   SD_WIDTH   : width of a packed twiddle pair (odd lane in the upper half)
//   ADDR_WIDTH : twiddle ROM address width
//   NUM_GROUPS : butterfly groups per radix-16 stage (16384/16)
//   P_ONE      : constant-one operand the multiplier mux uses when Mul_sel=0
//   twState_e  : fetch sequencer states
//   twMask()   : stage index -> twiddle address mask (16^stage - 1)
package ntt_tw_pkg;

  localparam int P_WIDTH    = 64;
  localparam int SD_WIDTH   = 128;
  localparam int ADDR_WIDTH = 10;
  localparam int NUM_GROUPS = 1024;

  localparam logic [P_WIDTH-1:0] P_ONE = 64'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } twState_e;

  // Stage s uses 16^s distinct twiddles, so the group index is masked to
  // its low 4*s bits. Stage 0 needs no twiddles and gets an empty mask.
  function automatic logic [15:0] twMask(input logic [1:0] stage);
    return 16'((32'd1 << (4 * stage)) - 32'd1);
  endfunction

endpackage

// File: rtl/tw_addr_gen.sv
// Group counter and twiddle address generator for one NTT stage.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count at group 0
//   adv      : step to the next group
//   stageR   : latched stage index, selects the address mask
//   grpAddr  : masked ROM address for the current group
//   lastGrp  : current group is the final one of the stage
module tw_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_GROUPS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [1:0]            stageR,
  output logic [ADDR_WIDTH-1:0] grpAddr,
  output logic                  lastGrp
);
  import ntt_tw_pkg::*;

  localparam int CNT_W = $clog2(NUM_GROUPS);

  logic [CNT_W-1:0] grpCnt;
  logic [15:0]      cntExt;
  logic [15:0]      maskedCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grpCnt <= '0;
    end else if (clr) begin
      grpCnt <= '0;
    end else if (adv) begin
      grpCnt <= grpCnt + 1'b1;
    end
  end

  // The counter itself never wraps within a stage; only the address does.
  assign cntExt    = 16'(grpCnt);
  assign maskedCnt = cntExt & twMask(stageR);
  assign grpAddr   = maskedCnt[ADDR_WIDTH-1:0];
  assign lastGrp   = (grpCnt == CNT_W'(NUM_GROUPS - 1));

endmodule

// File: rtl/tw_rom_fetch.sv
// Twiddle fetch sequencer for one radix-16 NTT stage. Walks the group
// index, reads the eight twiddle ROM banks and presents the words on the
// ROMD constant bus with a valid/ready handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   start, stage        : run request and stage index (taken in IDLE only)
//   rom_rd_en, rom_addr : shared read port to the eight ROM banks
//   rom_q0..rom_q7      : bank read data (bank 0 single word, 1..7 pairs)
//   ROMD0..ROMD7_in_const128 : registered twiddle words
//   Mul_sel             : 1 = ROM twiddles, 0 = constant one on all lanes
//   out_valid/out_ready : group handshake toward the multipliers
//   busy, done          : run status; done pulses once per completed stage
module tw_rom_fetch #(
  parameter int P_WIDTH    = 64,
  parameter int SD_WIDTH   = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_GROUPS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            stage,
  output logic                  rom_rd_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [P_WIDTH-1:0]    rom_q0,
  input  logic [SD_WIDTH-1:0]   rom_q1,
  input  logic [SD_WIDTH-1:0]   rom_q2,
  input  logic [SD_WIDTH-1:0]   rom_q3,
  input  logic [SD_WIDTH-1:0]   rom_q4,
  input  logic [SD_WIDTH-1:0]   rom_q5,
  input  logic [SD_WIDTH-1:0]   rom_q6,
  input  logic [SD_WIDTH-1:0]   rom_q7,
  output logic [P_WIDTH-1:0]    ROMD0_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD1_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD2_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD3_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD4_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD5_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD6_in_const128,
  output logic [SD_WIDTH-1:0]   ROMD7_in_const128,
  output logic                  Mul_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  import ntt_tw_pkg::*;

  twState_e              state;
  logic [1:0]            stageR;
  logic                  en;
  logic                  fetchIssue;
  logic                  bypass;
  logic                  newGrp_p1;
  logic [ADDR_WIDTH-1:0] grpAddr;
  logic                  lastGrp;

  logic                  issVld_p0;
  logic                  rdEnR_p0;
  logic [ADDR_WIDTH-1:0] romAddr_p0;
  logic                  qVld_p1;

  // One global advance: a stalled output freezes every stage, and the ROM
  // read enable is gated too so the ROM q stays aligned with qVld_p1.
  assign en         = ~out_valid | out_ready;
  assign fetchIssue = (state == FETCH) & en;
  assign bypass     = (stageR == 2'd0);
  assign newGrp_p1  = bypass ? issVld_p0 : qVld_p1;

  assign rom_rd_en = rdEnR_p0 & en;
  assign rom_addr  = romAddr_p0;

  tw_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_GROUPS(NUM_GROUPS)
  ) uAddrGen (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state == IDLE) & start),
    .adv    (fetchIssue & ~lastGrp),
    .stageR (stageR),
    .grpAddr(grpAddr),
    .lastGrp(lastGrp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stageR     <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      issVld_p0  <= 1'b0;
      rdEnR_p0   <= 1'b0;
      romAddr_p0 <= '0;
      qVld_p1    <= 1'b0;
      out_valid  <= 1'b0;
      Mul_sel    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= FETCH;
            stageR <= stage;
            busy   <= 1'b1;
          end
        end
        FETCH: begin
          if (en && lastGrp) state <= DRAIN;
        end
        DRAIN: begin
          if (!issVld_p0 && !qVld_p1 && !out_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (en) begin
        // p0: group issued, ROM read request registered
        issVld_p0 <= fetchIssue;
        rdEnR_p0  <= fetchIssue & ~bypass;
        if (fetchIssue) romAddr_p0 <= grpAddr;
        // p1: ROM q valid for the issued group (bypass groups skip the ROM)
        qVld_p1   <= issVld_p0 & ~bypass;
        // p2: group presented on the constant bus
        if (newGrp_p1) begin
          out_valid <= 1'b1;
          Mul_sel   <= ~bypass;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // p2: twiddle words captured only for ROM groups; bypass leaves them held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ROMD0_in_const128 <= '0;
      ROMD1_in_const128 <= '0;
      ROMD2_in_const128 <= '0;
      ROMD3_in_const128 <= '0;
      ROMD4_in_const128 <= '0;
      ROMD5_in_const128 <= '0;
      ROMD6_in_const128 <= '0;
      ROMD7_in_const128 <= '0;
    end else if (en && qVld_p1) begin
      ROMD0_in_const128 <= rom_q0;
      ROMD1_in_const128 <= rom_q1;
      ROMD2_in_const128 <= rom_q2;
      ROMD3_in_const128 <= rom_q3;
      ROMD4_in_const128 <= rom_q4;
      ROMD5_in_const128 <= rom_q5;
      ROMD6_in_const128 <= rom_q6;
      ROMD7_in_const128 <= rom_q7;
    end
  end

endmodule
